// File: rtl/clk_div_pkg.sv
// Shared types and constants for the integer clock-divide controller.
package clk_div_pkg;

    // Default width of the divide ratio; the maximum ratio is 2^width-1.
    localparam int DEF_DIV_W = 4;

    // Controller states. In SWITCH a new ratio is parked until the period boundary.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } div_state_e;

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter: counts 0..div_active-1 and flags the last cycle of a period.
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIV_W-1:0] div_active,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt;

    // Last cycle of the current period; decoded from the count flop and ratio flop only.
    assign wrap = (cnt == (div_active - DIV_W'(1)));

    // Count register: cleared on request, wraps to 0 at the period boundary.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (advance) begin
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock-divide controller: emits a one-cycle enable every N clk_in
// cycles, with N changed through a valid/ready handshake at period boundaries.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_en,
    output logic [DIV_W-1:0] div_active,
    output logic             busy
);

    div_state_e       state;
    logic [DIV_W-1:0] pend;
    logic             wrap;
    logic             accept;
    logic             accept_ok;
    logic             cnt_clear;
    logic             cnt_advance;

    // A ratio is only taken when no change is already parked.
    assign cfg_ready = (state != SWITCH);
    assign busy      = (state != IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign accept_ok = accept && (cfg_div != '0);

    // The counter sits at 0 while idle and is zeroed on the way back to idle.
    assign cnt_clear   = (state == IDLE) || !run;
    assign cnt_advance = (state != IDLE);

    // Enable is a pure flop decode, so no input reaches it combinationally.
    assign clk_en = (state != IDLE) && wrap;

    clk_div_cnt #(
        .DIV_W (DIV_W)
    ) u_cnt (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .clear      (cnt_clear),
        .advance    (cnt_advance),
        .div_active (div_active),
        .wrap       (wrap)
    );

    // Control FSM: ratio handshake, parked-ratio switchover and zero-ratio error pulse.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            div_active <= DIV_W'(DEFAULT_DIV);
            pend       <= '0;
            cfg_err    <= 1'b0;
        end else begin
            // A zero ratio is dropped; only the error pulse records it.
            cfg_err <= accept && (cfg_div == '0);
            case (state)
                IDLE: begin
                    if (accept_ok) begin
                        div_active <= cfg_div;
                    end
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        // Stopping wins over a concurrent ratio, which then loads directly.
                        state <= IDLE;
                        if (accept_ok) begin
                            div_active <= cfg_div;
                        end
                    end else if (accept_ok) begin
                        // Even on a boundary cycle the new ratio waits for the next boundary.
                        pend  <= cfg_div;
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    if (!run) begin
                        div_active <= pend;
                        state      <= IDLE;
                    end else if (wrap) begin
                        div_active <= pend;
                        state      <= RUN;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
